// File: rtl/mem_stage_rsp_if.sv
// Memory-stage pipeline bundle: Execute->Memory payload, Memory->Writeback payload,
// data-response channel, flush and forwarding bus. The slave side is the memory stage.
interface mem_stage_rsp_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            W_allowin;
  logic            M_allowin;
  logic            EM_valid;
  logic [XLEN-1:0] em_pc;
  logic [XLEN-1:0] em_alu_result;
  logic            em_gr_we;
  logic [RA_W-1:0] em_dest;
  logic [3:0]      em_mem_type;
  logic            em_mem_req;
  logic            flush;
  logic            data_ok;
  logic [XLEN-1:0] data_rdata;
  logic            MW_valid;
  logic [XLEN-1:0] mw_pc;
  logic [XLEN-1:0] mw_result;
  logic            mw_gr_we;
  logic [RA_W-1:0] mw_dest;
  logic [RA_W-1:0] fwd_dest;
  logic [XLEN-1:0] fwd_data;
  logic            fwd_pending;

  modport slave (
    input  W_allowin, EM_valid, em_pc, em_alu_result, em_gr_we, em_dest,
           em_mem_type, em_mem_req, flush, data_ok, data_rdata,
    output M_allowin, MW_valid, mw_pc, mw_result, mw_gr_we, mw_dest,
           fwd_dest, fwd_data, fwd_pending
  );

  modport master (
    output W_allowin, EM_valid, em_pc, em_alu_result, em_gr_we, em_dest,
           em_mem_type, em_mem_req, flush, data_ok, data_rdata,
    input  M_allowin, MW_valid, mw_pc, mw_result, mw_gr_we, mw_dest,
           fwd_dest, fwd_data, fwd_pending
  );
endinterface

// File: rtl/mem_stage_rsp.sv
// Memory pipeline stage for split-transaction loads: waits for data_ok, buffers a response
// under Writeback stall, drops responses of flushed loads and extracts sub-word load data.
module mem_stage_rsp_chk #(
  parameter int CNT_W      = 2,
  parameter int MAX_CANCEL = 3
) (
  input logic             clk,
  input logic             rstn,
  input logic             cancel_inc,
  input logic             cancel_dec,
  input logic [CNT_W-1:0] cancel_cnt
);
  // More flushed-but-unanswered loads than the counter can track is a configuration error.
  property p_cancel_no_overflow;
    @(posedge clk) disable iff (!rstn)
      !(cancel_inc && !cancel_dec && (cancel_cnt == CNT_W'(MAX_CANCEL)));
  endproperty
  a_cancel_no_overflow: assert property (p_cancel_no_overflow);
endmodule

module mem_stage_rsp #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int MAX_CANCEL = 3
) (
  input logic            clk,
  input logic            rstn,
  mem_stage_rsp_if.slave bus
);
  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int CNT_W = $clog2(MAX_CANCEL + 1);

  logic             m_valid_r;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  alu_r;
  logic             gr_we_r;
  logic [RA_W-1:0]  dest_r;
  logic [3:0]       mem_type_r;
  logic             req_r;
  logic             rsp_got_r;
  logic [XLEN-1:0]  rsp_buf_r;
  logic [CNT_W-1:0] cancel_cnt_r;
  logic [CNT_W-1:0] cancel_nxt_s;

  logic             no_cancel_s;
  logic             discard_s;
  logic             owned_s;
  logic             ready_go_s;
  logic             allowin_s;
  logic             accept_s;
  logic             cancel_inc_s;
  logic             capture_s;
  logic [OFF_W-1:0] off_s;
  logic [XLEN-1:0]  ld_raw_s;
  logic [7:0]       byte_s;
  logic [15:0]      half_s;
  logic [31:0]      word_s;
  logic [XLEN-1:0]  ld_ext_s;
  logic [XLEN-1:0]  result_s;

  assign no_cancel_s  = (cancel_cnt_r == CNT_W'(0));
  assign discard_s    = bus.data_ok & ~no_cancel_s;
  assign owned_s      = bus.data_ok & no_cancel_s & m_valid_r & req_r & ~rsp_got_r;
  assign ready_go_s   = ~req_r | rsp_got_r | (bus.data_ok & no_cancel_s);
  assign allowin_s    = ~m_valid_r | (ready_go_s & bus.W_allowin);
  assign accept_s     = bus.EM_valid & allowin_s;
  assign capture_s    = owned_s & ~bus.W_allowin;
  assign cancel_inc_s = bus.flush & m_valid_r & req_r & ~rsp_got_r & ~owned_s;

  // A flush and a discarded response in the same cycle cancel each other out.
  always_comb begin
    cancel_nxt_s = cancel_cnt_r;
    if (cancel_inc_s && !discard_s) begin
      if (cancel_cnt_r != CNT_W'(MAX_CANCEL)) begin
        cancel_nxt_s = cancel_cnt_r + CNT_W'(1);
      end else begin
        cancel_nxt_s = cancel_cnt_r;
      end
    end else if (discard_s && !cancel_inc_s) begin
      cancel_nxt_s = cancel_cnt_r - CNT_W'(1);
    end else begin
      cancel_nxt_s = cancel_cnt_r;
    end
  end

  // Stage state: valid bit, instruction payload, response buffer and cancel counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_valid_r    <= 1'b0;
      pc_r         <= '0;
      alu_r        <= '0;
      gr_we_r      <= 1'b0;
      dest_r       <= '0;
      mem_type_r   <= 4'b0000;
      req_r        <= 1'b0;
      rsp_got_r    <= 1'b0;
      rsp_buf_r    <= '0;
      cancel_cnt_r <= '0;
    end else begin
      if (bus.flush && m_valid_r) begin
        m_valid_r <= 1'b0;
      end else if (allowin_s) begin
        m_valid_r <= bus.EM_valid;
      end else begin
        m_valid_r <= m_valid_r;
      end
      if (accept_s) begin
        pc_r       <= bus.em_pc;
        alu_r      <= bus.em_alu_result;
        gr_we_r    <= bus.em_gr_we;
        dest_r     <= bus.em_dest;
        mem_type_r <= bus.em_mem_type;
        req_r      <= bus.em_mem_req;
        rsp_got_r  <= 1'b0;
      end else if (capture_s) begin
        rsp_got_r  <= 1'b1;
      end
      if (capture_s) begin
        rsp_buf_r <= bus.data_rdata;
      end
      cancel_cnt_r <= cancel_nxt_s;
    end
  end

  assign off_s    = alu_r[OFF_W-1:0];
  assign ld_raw_s = rsp_got_r ? rsp_buf_r : bus.data_rdata;
  assign byte_s   = ld_raw_s[{off_s, 3'b000} +: 8];
  assign half_s   = ld_raw_s[{off_s[OFF_W-1:1], 4'b0000} +: 16];

  if (XLEN == 64) begin : g_word64
    assign word_s = ld_raw_s[{off_s[OFF_W-1], 5'b00000} +: 32];
  end else begin : g_word32
    assign word_s = ld_raw_s[31:0];
  end

  // Sub-word selection with sign/zero extension; word beats half beats byte.
  always_comb begin
    ld_ext_s = '0;
    if (mem_type_r[3]) begin
      ld_ext_s = mem_type_r[2] ? XLEN'(word_s) : XLEN'($signed(word_s));
    end else if (mem_type_r[1]) begin
      ld_ext_s = mem_type_r[2] ? XLEN'(half_s) : XLEN'($signed(half_s));
    end else begin
      ld_ext_s = mem_type_r[2] ? XLEN'(byte_s) : XLEN'($signed(byte_s));
    end
  end

  assign result_s        = (mem_type_r == 4'b0000) ? alu_r : ld_ext_s;

  assign bus.M_allowin   = allowin_s;
  assign bus.MW_valid    = m_valid_r & ready_go_s & ~bus.flush;
  assign bus.mw_pc       = pc_r;
  assign bus.mw_result   = result_s;
  assign bus.mw_gr_we    = gr_we_r;
  assign bus.mw_dest     = dest_r;
  assign bus.fwd_dest    = (m_valid_r & gr_we_r) ? dest_r : '0;
  assign bus.fwd_data    = result_s;
  assign bus.fwd_pending = m_valid_r & gr_we_r & req_r & ~ready_go_s;

  mem_stage_rsp_chk #(
    .CNT_W      (CNT_W),
    .MAX_CANCEL (MAX_CANCEL)
  ) u_chk (
    .clk        (clk),
    .rstn       (rstn),
    .cancel_inc (cancel_inc_s),
    .cancel_dec (discard_s),
    .cancel_cnt (cancel_cnt_r)
  );
endmodule

// File: tb/tb_mem_stage_rsp.sv
// Scoreboard bench for mem_stage_rsp: 32-bit and 64-bit instances, expected results queued
// at issue and compared whenever an instruction leaves towards Writeback.
module tb_mem_stage_rsp;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_stage_rsp_if #(.XLEN(32), .RA_W(5)) b32 ();
  mem_stage_rsp_if #(.XLEN(64), .RA_W(5)) b64 ();

  mem_stage_rsp #(.XLEN(32), .RA_W(5), .MAX_CANCEL(3)) u32 (.clk(clk), .rstn(rstn), .bus(b32));
  mem_stage_rsp #(.XLEN(64), .RA_W(5), .MAX_CANCEL(3)) u64 (.clk(clk), .rstn(rstn), .bus(b64));

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] res;
    logic [4:0]  dest;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32;
  exp_t e64;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 32-bit stage: pop on every hand-off to Writeback.
  always @(negedge clk) begin
    if (rstn && b32.MW_valid && b32.W_allowin) begin
      if (q32.size() == 0) begin
        check_eq("sb32_spurious_MW_valid", 64'(b32.MW_valid), 64'd0);
      end else begin
        e32 = q32.pop_front();
        check_eq("sb32_pc", 64'(b32.mw_pc), e32.pc);
        check_eq("sb32_result", 64'(b32.mw_result), e32.res);
        check_eq("sb32_fwd_data", 64'(b32.fwd_data), e32.res);
        check_eq("sb32_dest", 64'(b32.mw_dest), 64'(e32.dest));
      end
    end
  end

  // Scoreboard for the 64-bit stage.
  always @(negedge clk) begin
    if (rstn && b64.MW_valid && b64.W_allowin) begin
      if (q64.size() == 0) begin
        check_eq("sb64_spurious_MW_valid", 64'(b64.MW_valid), 64'd0);
      end else begin
        e64 = q64.pop_front();
        check_eq("sb64_pc", b64.mw_pc, e64.pc);
        check_eq("sb64_result", b64.mw_result, e64.res);
        check_eq("sb64_dest", 64'(b64.mw_dest), 64'(e64.dest));
      end
    end
  end

  task automatic issue32(input logic [31:0] pc, input logic [31:0] alu, input logic [3:0] mt,
                         input logic req, input logic [4:0] dest, input logic push,
                         input logic [31:0] res);
    b32.EM_valid      = 1'b1;
    b32.em_pc         = pc;
    b32.em_alu_result = alu;
    b32.em_gr_we      = 1'b1;
    b32.em_dest       = dest;
    b32.em_mem_type   = mt;
    b32.em_mem_req    = req;
    if (push) q32.push_back('{pc: 64'(pc), res: 64'(res), dest: dest});
    tick();
    b32.EM_valid = 1'b0;
  endtask

  task automatic load32(input logic [31:0] addr, input logic [3:0] mt, input logic [31:0] rd,
                        input logic [31:0] res, input int lat);
    issue32(addr + 32'h0000_0100, addr, mt, 1'b1, 5'd9, 1'b1, res);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check_eq("ld32_wait_pending", 64'(b32.fwd_pending), 64'd1);
      check_eq("ld32_wait_MW_valid", 64'(b32.MW_valid), 64'd0);
      tick();
    end
    b32.data_ok    = 1'b1;
    b32.data_rdata = rd;
    @(negedge clk);
    check_eq("ld32_rsp_MW_valid", 64'(b32.MW_valid), 64'd1);
    tick();
    b32.data_ok    = 1'b0;
    b32.data_rdata = 32'h0;
  endtask

  task automatic load64(input logic [63:0] addr, input logic [3:0] mt, input logic [63:0] rd,
                        input logic [63:0] res);
    b64.EM_valid      = 1'b1;
    b64.em_pc         = addr + 64'h100;
    b64.em_alu_result = addr;
    b64.em_gr_we      = 1'b1;
    b64.em_dest       = 5'd17;
    b64.em_mem_type   = mt;
    b64.em_mem_req    = (mt != 4'b0000);
    q64.push_back('{pc: addr + 64'h100, res: res, dest: 5'd17});
    tick();
    b64.EM_valid   = 1'b0;
    b64.data_ok    = (mt != 4'b0000);
    b64.data_rdata = rd;
    @(negedge clk);
    check_eq("ld64_MW_valid", 64'(b64.MW_valid), 64'd1);
    tick();
    b64.data_ok    = 1'b0;
    b64.data_rdata = 64'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    b32.W_allowin = 1'b1; b32.EM_valid = 1'b0; b32.em_pc = '0; b32.em_alu_result = '0;
    b32.em_gr_we = 1'b0; b32.em_dest = '0; b32.em_mem_type = 4'b0000; b32.em_mem_req = 1'b0;
    b32.flush = 1'b0; b32.data_ok = 1'b0; b32.data_rdata = '0;
    b64.W_allowin = 1'b1; b64.EM_valid = 1'b0; b64.em_pc = '0; b64.em_alu_result = '0;
    b64.em_gr_we = 1'b0; b64.em_dest = '0; b64.em_mem_type = 4'b0000; b64.em_mem_req = 1'b0;
    b64.flush = 1'b0; b64.data_ok = 1'b0; b64.data_rdata = '0;

    tick(); tick();
    @(negedge clk);
    check_eq("rst_MW_valid", 64'(b32.MW_valid), 64'd0);
    check_eq("rst_fwd_dest", 64'(b32.fwd_dest), 64'd0);
    check_eq("rst_fwd_pending", 64'(b32.fwd_pending), 64'd0);
    check_eq("rst_mw_result", 64'(b32.mw_result), 64'd0);
    check_eq("rst64_MW_valid", 64'(b64.MW_valid), 64'd0);
    tick();
    rstn = 1'b1;

    // ALU op without a memory request
    issue32(32'h1C00_0000, 32'h0000_0055, 4'b0000, 1'b0, 5'd3, 1'b1, 32'h0000_0055);
    @(negedge clk);
    check_eq("alu_MW_valid", 64'(b32.MW_valid), 64'd1);
    check_eq("alu_fwd_dest", 64'(b32.fwd_dest), 64'd3);
    check_eq("alu_fwd_pending", 64'(b32.fwd_pending), 64'd0);
    tick();
    @(negedge clk);
    check_eq("alu_MW_valid_after", 64'(b32.MW_valid), 64'd0);
    check_eq("alu_fwd_dest_after", 64'(b32.fwd_dest), 64'd0);
    tick();

    // Sub-word extraction, sign/zero extension and width priority
    load32(32'h1C00_1003, 4'b0001, 32'h80AB_CDEF, 32'hFFFF_FF80, 2);
    load32(32'h1C00_1002, 4'b0110, 32'h80AB_CDEF, 32'h0000_80AB, 2);
    load32(32'h1C00_1000, 4'b0010, 32'h80AB_CDEF, 32'hFFFF_CDEF, 1);
    load32(32'h1C00_1001, 4'b0101, 32'h80AB_CDEF, 32'h0000_00CD, 0);
    load32(32'h1C00_1002, 4'b0001, 32'h007F_0000, 32'h0000_007F, 1);
    load32(32'h1C00_1001, 4'b1011, 32'h8000_0001, 32'h8000_0001, 1);
    load32(32'h1C00_1000, 4'b0011, 32'h0000_80FF, 32'hFFFF_80FF, 1);

    // Response arrives while Writeback is stalled
    issue32(32'h1C00_3100, 32'h1C00_3000, 4'b1000, 1'b1, 5'd10, 1'b1, 32'h1234_5678);
    b32.W_allowin  = 1'b0;
    b32.data_ok    = 1'b1;
    b32.data_rdata = 32'h1234_5678;
    @(negedge clk);
    check_eq("stall_rsp_MW_valid", 64'(b32.MW_valid), 64'd1);
    check_eq("stall_rsp_result", 64'(b32.mw_result), 64'h1234_5678);
    check_eq("stall_M_allowin", 64'(b32.M_allowin), 64'd0);
    tick();
    b32.data_ok    = 1'b0;
    b32.data_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("stall_rsp_got", 64'(u32.rsp_got_r), 64'd1);
      check_eq("stall_hold_MW_valid", 64'(b32.MW_valid), 64'd1);
      check_eq("stall_hold_result", 64'(b32.mw_result), 64'h1234_5678);
      check_eq("stall_hold_pending", 64'(b32.fwd_pending), 64'd0);
      tick();
    end
    b32.W_allowin = 1'b1;
    @(negedge clk);
    check_eq("stall_release_allowin", 64'(b32.M_allowin), 64'd1);
    tick();
    b32.data_rdata = 32'h0;
    @(negedge clk);
    check_eq("stall_left_MW_valid", 64'(b32.MW_valid), 64'd0);
    tick();

    // Flush a pending load; its late response must be dropped
    issue32(32'h1C00_4100, 32'h1C00_4000, 4'b1000, 1'b1, 5'd11, 1'b0, 32'h0);
    b32.flush = 1'b1;
    @(negedge clk);
    check_eq("flush_MW_valid", 64'(b32.MW_valid), 64'd0);
    tick();
    b32.flush = 1'b0;
    @(negedge clk);
    check_eq("flush_cancel_cnt", 64'(u32.cancel_cnt_r), 64'd1);
    check_eq("flush_fwd_dest", 64'(b32.fwd_dest), 64'd0);
    issue32(32'h1C00_4200, 32'h1C00_4004, 4'b1000, 1'b1, 5'd12, 1'b1, 32'h0000_BEEF);
    b32.data_ok    = 1'b1;
    b32.data_rdata = 32'h0000_DEAD;
    @(negedge clk);
    check_eq("drop_MW_valid", 64'(b32.MW_valid), 64'd0);
    check_eq("drop_fwd_pending", 64'(b32.fwd_pending), 64'd1);
    tick();
    b32.data_rdata = 32'h0000_BEEF;
    @(negedge clk);
    check_eq("drop_cancel_cnt", 64'(u32.cancel_cnt_r), 64'd0);
    check_eq("own_MW_valid", 64'(b32.MW_valid), 64'd1);
    tick();
    b32.data_ok    = 1'b0;
    b32.data_rdata = 32'h0;

    // Reset in the middle of a wait clears the cancel counter
    issue32(32'h1C00_5100, 32'h1C00_5000, 4'b1000, 1'b1, 5'd13, 1'b0, 32'h0);
    b32.flush = 1'b1;
    tick();
    b32.flush = 1'b0;
    issue32(32'h1C00_5200, 32'h1C00_5004, 4'b1000, 1'b1, 5'd14, 1'b0, 32'h0);
    @(negedge clk);
    check_eq("prerst_pending", 64'(b32.fwd_pending), 64'd1);
    check_eq("prerst_cancel_cnt", 64'(u32.cancel_cnt_r), 64'd1);
    tick();
    rstn = 1'b0;
    tick();
    @(negedge clk);
    check_eq("midrst_MW_valid", 64'(b32.MW_valid), 64'd0);
    check_eq("midrst_fwd_dest", 64'(b32.fwd_dest), 64'd0);
    check_eq("midrst_fwd_pending", 64'(b32.fwd_pending), 64'd0);
    check_eq("midrst_mw_result", 64'(b32.mw_result), 64'd0);
    check_eq("midrst_mw_pc", 64'(b32.mw_pc), 64'd0);
    check_eq("midrst_cancel_cnt", 64'(u32.cancel_cnt_r), 64'd0);
    rstn = 1'b1;
    tick();
    load32(32'h1C00_6000, 4'b1000, 32'h0000_0042, 32'h0000_0042, 1);

    // 64-bit datapath
    load64(64'h0000_0000_1C00_7004, 4'b1000, 64'h89AB_CDEF_0123_4567, 64'hFFFF_FFFF_89AB_CDEF);
    load64(64'h0000_0000_1C00_7000, 4'b1100, 64'h89AB_CDEF_0123_4567, 64'h0000_0000_0123_4567);
    load64(64'h0000_0000_1C00_7006, 4'b0001, 64'h89AB_CDEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFAB);
    load64(64'h0000_0000_1C00_7002, 4'b0010, 64'h89AB_CDEF_0123_4567, 64'h0000_0000_0000_0123);
    load64(64'h0000_0000_1C00_7007, 4'b0101, 64'h89AB_CDEF_0123_4567, 64'h0000_0000_0000_0089);
    load64(64'h1234_5678_9ABC_DEF0, 4'b0000, 64'h0, 64'h1234_5678_9ABC_DEF0);

    tick(); tick();
    check_eq("sb32_drained", 64'(q32.size()), 64'd0);
    check_eq("sb64_drained", 64'(q64.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_rsp.md
Name: mem_stage_rsp

Overview:
Parametrised successor to the single-cycle memory pipeline stage. It sits between the Execute and Writeback stages and follows the same valid/allowin pipeline handshake. It waits for split-transaction data responses (data_ok) instead of assuming same-cycle read data, and extracts sub-word load data by address offset. It buffers a response that arrives while Writeback is stalled, drops responses that belong to flushed loads, and drives a forwarding bus with a load-pending indication.

Parameters:
XLEN, 32, datapath width; must be 32 or 64.
RA_W, 5, register index width.
MAX_CANCEL, 3, maximum number of flushed-but-unanswered loads tracked; the cancel counter is $clog2(MAX_CANCEL+1) bits.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
W_allowin  in  1  Writeback can accept
M_allowin  out  1  this stage can accept
EM_valid  in  1  Execute output valid
em_pc  in  XLEN  instruction PC
em_alu_result  in  XLEN  ALU result; also the load address
em_gr_we  in  1  register write enable
em_dest  in  RA_W  destination register
em_mem_type  in  4  [3] word, [2] unsigned, [1] half, [0] byte; all zero = not a load
em_mem_req  in  1  a data read request was accepted for this instruction (addr_ok already seen)
flush  in  1  cancel the instruction held in this stage
data_ok  in  1  read response valid; responses arrive in order
data_rdata  in  XLEN  read response data
MW_valid  out  1  output to Writeback valid
mw_pc  out  XLEN  PC
mw_result  out  XLEN  final result
mw_gr_we  out  1  write enable
mw_dest  out  RA_W  destination
fwd_dest  out  RA_W  forward destination; 0 when no valid write
fwd_data  out  XLEN  forward data
fwd_pending  out  1  a valid load is waiting for its response; Decode must stall, not forward

Behaviour:
- Reset (rstn=0 at a clk edge):
  - M_valid=0, payload registers=0, rsp_got=0, rsp_buf=0, cancel_cnt=0.
  - Resulting outputs: MW_valid=0, fwd_dest=0, fwd_pending=0; mw_* and fwd_data read 0.
- Handshake:
  - M_ready_go = !req_M | rsp_got | (data_ok && cancel_cnt==0).
  - M_allowin = !M_valid | (M_ready_go & W_allowin).
  - MW_valid = M_valid & M_ready_go & !flush.
- Accepting a new instruction: on EM_valid & M_allowin, latch the payload, set M_valid=1, clear rsp_got. If M_allowin & !EM_valid, M_valid becomes 0.
- Response ownership:
  - A data_ok with cancel_cnt>0 is discarded and cancel_cnt decrements; it never reaches the current instruction.
  - Otherwise it belongs to the current instruction when M_valid & req_M & !rsp_got.
- Response buffering: if an owned response arrives and the instruction does not leave this cycle (W_allowin=0), capture data_rdata into rsp_buf and set rsp_got=1. Load data comes from rsp_buf when rsp_got=1, else from data_rdata.
- Zero latency: a response arriving in the same cycle as W_allowin=1 passes straight to mw_result in that cycle.
- Load extraction (off = alu_result[$clog2(XLEN/8)-1:0]):
  - byte = rdata[8*off +: 8]
  - half = rdata[16*off[hi:1] +: 16]
  - word = rdata[32*off[hi:2] +: 32] when XLEN=64, else rdata
  - Sign-extend unless [2] is set. Priority: word > half > byte.
  - mw_result = ALU result when mem_type==0.
- Flush:
  - Sets M_valid=0 next cycle and forces MW_valid=0 in the current cycle.
  - If M_valid & req_M & !rsp_got and no owned data_ok arrives this cycle, cancel_cnt increments.
  - If the counter is at MAX_CANCEL, it saturates; that is an illegal configuration, flagged by a simulation assertion.
  - A flush and a discarding data_ok in the same cycle net to no change in cancel_cnt.
  - Flush with M_valid=0 has no effect.
- Forwarding:
  - fwd_dest = dest_M when M_valid & gr_we_M, else 0.
  - fwd_data = the same value as mw_result.
  - fwd_pending = M_valid & gr_we_M & req_M & !M_ready_go.

Test Plan:
1. ALU op, no request: EM pc=0x1C000000, result=0x55, dest=3; W_allowin=1 -> MW_valid is 1 for one cycle after acceptance; mw_result=0x55; fwd_dest=3; fwd_pending=0.
2. lb at addr 0x...03, data_ok two cycles later with rdata=0x80AB_CDEF:
   - fwd_pending=1 and MW_valid=0 while waiting.
   - On the response cycle, mw_result=0xFFFFFF80 and MW_valid=1.
   - With lhu at addr 0x...02 instead, mw_result=0x000080AB.
3. Response while W_allowin=0: lw gets data_ok with rdata=0x12345678, W_allowin held low for 3 cycles -> rsp_got=1, MW_valid=1 and the result stays 0x12345678 throughout; the instruction leaves on the cycle W_allowin rises.
4. Flush a pending load, then the next lw enters with a request:
   - cancel_cnt goes 0 -> 1 after the flush.
   - The first data_ok (0xDEAD) is dropped and cancel_cnt returns to 0.
   - The second data_ok (0xBEEF) completes the new lw with mw_result=0x0000BEEF.
5. Reset asserted mid-wait (load pending, cancel_cnt=1) -> next cycle all outputs are 0 and cancel_cnt=0; a subsequent lw completes on its first data_ok.
6. XLEN=64: lw at offset 4, rdata=0x89ABCDEF_01234567 -> mw_result=0xFFFFFFFF_89ABCDEF.
